// File: rtl/pipelined_adder.sv
// Segmented, carry-pipelined add/subtract. Each stage adds one SEG_WIDTH slice and
// registers its carry; operand slices not yet consumed ride along in a shrinking skew chain.

module pipelined_adder_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module pipelined_adder #(
  parameter int WIDTH     = 45,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH:0]   sum
);
  localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

  // B skew chain is packed triangularly: slice k holds b'[WIDTH-1 : k*SEG_WIDTH].
  function automatic int boff(input int k);
    return k * WIDTH - (SEG_WIDTH * k * (k - 1)) / 2;
  endfunction
  localparam int BTOT = boff(NSEG);

  // x_q[k]: low k segments are result, upper bits are still operand A.
  logic [NSEG:0][WIDTH-1:0] x_d, x_q;
  logic [NSEG:0]            c_d, c_q, vld_pipe;
  logic [BTOT-1:0]          b_d, b_q;

  assign x_d[0]         = a;
  assign c_d[0]         = sub | cin;
  assign b_d[WIDTH-1:0] = sub ? ~b : b;

  genvar k;
  for (k = 1; k <= NSEG; k++) begin : g_seg
    localparam int LO = (k - 1) * SEG_WIDTH;
    localparam int SW = (k == NSEG) ? WIDTH - LO : SEG_WIDTH;
    localparam int BP = boff(k - 1);
    localparam logic [WIDTH-1:0] SEG_MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;
    logic [SW-1:0] s;

    pipelined_adder_seg #(.W(SW)) u_seg (
      .a    (x_q[k-1][LO +: SW]),
      .b    (b_q[BP +: SW]),
      .cin  (c_q[k-1]),
      .sum  (s),
      .cout (c_d[k])
    );

    assign x_d[k] = (x_q[k-1] & ~SEG_MASK) | (WIDTH'(s) << LO);

    if (k < NSEG) begin : g_b
      localparam int BN = boff(k);
      localparam int BW = WIDTH - k * SEG_WIDTH;
      assign b_d[BN +: BW] = b_q[BP + SEG_WIDTH +: BW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      c_q      <= '0;
      b_q      <= '0;
      vld_pipe <= '0;
    end else if (!stall) begin
      x_q      <= x_d;
      c_q      <= c_d;
      b_q      <= b_d;
      vld_pipe <= {vld_pipe[NSEG-1:0], in_valid};
    end
  end

  assign out_valid = vld_pipe[NSEG];
  assign sum       = {c_q[NSEG], x_q[NSEG]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: one 45/16 instance plus 8-bit instances at SEG 8, 3 and 1,
// each scored against a delay-line model of a+b+cin / a-b.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  logic        v45 = 1'b0, sub45 = 1'b0, cin45 = 1'b0;
  logic [44:0] a45 = '0, b45 = '0;
  logic        ov45;
  logic [45:0] s45;

  logic        v8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ov8a, ov8b, ov8c;
  logic [8:0]  s8a, s8b, s8c;

  pipelined_adder #(.WIDTH(45), .SEG_WIDTH(16)) u_d45 (
    .clk(clk), .reset(rst), .in_valid(v45), .a(a45), .b(b45), .sub(sub45), .cin(cin45),
    .stall(stall), .out_valid(ov45), .sum(s45));
  pipelined_adder #(.WIDTH(8), .SEG_WIDTH(8)) u_d8a (
    .clk(clk), .reset(rst), .in_valid(v8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .stall(stall), .out_valid(ov8a), .sum(s8a));
  pipelined_adder #(.WIDTH(8), .SEG_WIDTH(3)) u_d8b (
    .clk(clk), .reset(rst), .in_valid(v8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .stall(stall), .out_valid(ov8b), .sum(s8b));
  pipelined_adder #(.WIDTH(8), .SEG_WIDTH(1)) u_d8c (
    .clk(clk), .reset(rst), .in_valid(v8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .stall(stall), .out_valid(ov8c), .sum(s8c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: results live modulo 2^(w+1); subtract biases by 2^w so
  // bit w reads as "no borrow".
  function automatic logic [63:0] ref_sum(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input logic c);
    logic [63:0] m;
    m = (64'd1 << (w + 1)) - 64'd1;
    if (s) return (x + (64'd1 << w) - y) & m;
    return (x + y + 64'(c)) & m;
  endfunction

  // Delay-line models: entry = {valid, result}; index L-1 is what the output shows.
  logic [63:0] m45[4];
  logic [63:0] m8a[2];
  logic [63:0] m8b[4];
  logic [63:0] m8c[9];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m45[i] <= '0;
      for (int i = 0; i < 2; i++) m8a[i] <= '0;
      for (int i = 0; i < 4; i++) m8b[i] <= '0;
      for (int i = 0; i < 9; i++) m8c[i] <= '0;
    end else if (!stall) begin
      for (int i = 3; i > 0; i--) m45[i] <= m45[i-1];
      for (int i = 1; i > 0; i--) m8a[i] <= m8a[i-1];
      for (int i = 3; i > 0; i--) m8b[i] <= m8b[i-1];
      for (int i = 8; i > 0; i--) m8c[i] <= m8c[i-1];
      m45[0] <= {v45, 63'(ref_sum(45, 64'(a45), 64'(b45), sub45, cin45))};
      m8a[0] <= {v8, 63'(ref_sum(8, 64'(a8), 64'(b8), sub8, cin8))};
      m8b[0] <= {v8, 63'(ref_sum(8, 64'(a8), 64'(b8), sub8, cin8))};
      m8c[0] <= {v8, 63'(ref_sum(8, 64'(a8), 64'(b8), sub8, cin8))};
    end
  end

  task automatic check_outputs();
    chk("ov45", 64'(ov45), 64'(m45[3][63]));
    if (m45[3][63]) chk("sum45", 64'(s45), 64'(m45[3][45:0]));
    chk("ov8_s8", 64'(ov8a), 64'(m8a[1][63]));
    if (m8a[1][63]) chk("sum8_s8", 64'(s8a), 64'(m8a[1][8:0]));
    chk("ov8_s3", 64'(ov8b), 64'(m8b[3][63]));
    if (m8b[3][63]) chk("sum8_s3", 64'(s8b), 64'(m8b[3][8:0]));
    chk("ov8_s1", 64'(ov8c), 64'(m8c[8][63]));
    if (m8c[8][63]) chk("sum8_s1", 64'(s8c), 64'(m8c[8][8:0]));
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic dir45(input string tag, input logic [44:0] x, input logic [44:0] y,
                       input logic s, input logic c, input logic [45:0] exp);
    v45 = 1'b1; a45 = x; b45 = y; sub45 = s; cin45 = c;
    tick();
    v45 = 1'b0;
    repeat (3) tick();
    chk({tag, "_valid"}, 64'(ov45), 64'd1);
    chk(tag, 64'(s45), 64'(exp));
  endtask

  logic [63:0] hold;

  initial begin
    // reset held with live-looking inputs
    v45 = 1'b1; a45 = '1; b45 = '1;
    v8  = 1'b1; a8  = '1; b8  = '1;
    repeat (5) begin
      tick();
      chk("rst_ov45", 64'(ov45), 64'd0);
      chk("rst_sum45", 64'(s45), 64'd0);
      chk("rst_ov8", 64'({ov8a, ov8b, ov8c}), 64'd0);
    end
    rst = 1'b0; v8 = 1'b0;

    dir45("add_1_2", 45'd1, 45'd2, 1'b0, 1'b0, 46'd3);
    dir45("ripple_cin", '1, 45'd0, 1'b0, 1'b1, 46'h2000_0000_0000);
    dir45("ripple_full", '1, '1, 1'b0, 1'b1, '1);
    dir45("sub_nb", 45'd100, 45'd37, 1'b1, 1'b0, 46'h2000_0000_003F);
    dir45("sub_borrow", 45'd5, 45'd7, 1'b1, 1'b1, 46'h1FFF_FFFF_FFFE);

    // reset wins over stall, cleared asynchronously
    stall = 1'b1; rst = 1'b1;
    #1;
    chk("rst_stall_ov", 64'(ov45), 64'd0);
    chk("rst_stall_sum", 64'(s45), 64'd0);
    tick();
    rst = 1'b0; stall = 1'b0;

    // streaming with bubbles
    for (int i = 0; i < 30; i++) begin
      v45   = (i % 3 != 2);
      a45   = 45'({$urandom(), $urandom()});
      b45   = 45'({$urandom(), $urandom()});
      sub45 = 1'($urandom_range(1));
      cin45 = 1'($urandom_range(1));
      tick();
    end
    v45 = 1'b0;
    repeat (4) tick();

    // stall mid-flight: outputs frozen, stalled inputs dropped
    for (int i = 0; i < 3; i++) begin
      v45 = 1'b1; a45 = 45'($urandom()); b45 = 45'($urandom());
      sub45 = 1'(i & 1); cin45 = 1'b1;
      tick();
    end
    hold = 64'({ov45, s45});
    stall = 1'b1; v45 = 1'b1; a45 = '1; b45 = 45'd12345;
    repeat (3) begin
      tick();
      chk("stall_hold", 64'({ov45, s45}), hold);
    end
    stall = 1'b0; v45 = 1'b0;
    repeat (6) tick();

    // 8-bit sweep across three segmentations, with random stalls and a mid-stream reset
    for (int ai = 0; ai < 256; ai++) begin
      for (int j = 0; j < 8; j++) begin
        if (ai == 128 && j == 0) begin
          rst = 1'b1;
          #1;
          chk("midrst_ov8", 64'({ov8a, ov8b, ov8c}), 64'd0);
          chk("midrst_sum8", 64'({s8a, s8b, s8c}), 64'd0);
          tick();
          rst = 1'b0;
        end
        a8 = 8'(ai);
        case (j)
          0: b8 = 8'd0;
          1: b8 = 8'hFF;
          2: b8 = a8;
          3: b8 = ~a8;
          default: b8 = 8'($urandom());
        endcase
        sub8  = (j % 2 == 1);
        cin8  = 1'($urandom_range(1));
        v8    = ($urandom_range(7) != 0);
        stall = ($urandom_range(15) == 0);
        tick();
      end
    end
    stall = 1'b0; v8 = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
